mc_ctrl_fsm: RTL and testbench
==============================

MC_CTRL_FSM -- requirements
Module: mc_ctrl_fsm

Interface
REQ-001 SHALL have parameters (name, default, meaning):
  OP_W, 6, opcode width
  TMO_CYC, 15, max consecutive mem_ready=0 cycles before trap (>=1)
  TMO_W, 4, timeout counter width; SHALL satisfy 2**TMO_W > TMO_CYC
  IRQ_VEC_SEL, 3, pc_src code selecting the interrupt vector
REQ-002 SHALL have ports (name, direction, width, meaning):
  clk  in  1  single clock, rising edge
  rst_n  in  1  asynchronous active-low reset
  opcode  in  OP_W  opcode field of the instruction register
  mem_ready  in  1  memory completes the current access this cycle
  irq  in  1  level interrupt request
  alu_op  out  2  00 add, 01 sub, 10 funct, 11 logic-imm
  alu_src_a  out  1  0 PC, 1 register A
  alu_src_b  out  2  0 reg B, 1 const 4, 2 sign-ext imm, 3 imm<<2
  reg_dst  out  2  0 rt, 1 rd, 2 $31
  mem_to_reg  out  2  0 ALUOut, 1 MDR, 2 PC
  i_or_d, ir_write, mem_read, mem_write, pc_write, branch, branch_ne, reg_write  out  1 each  datapath strobes
  pc_src  out  2  0 ALU, 1 ALUOut, 2 jump target, IRQ_VEC_SEL vector
  irq_ack, illegal_op, mem_timeout  out  1 each  status
  state  out  4  current state code

Function
REQ-003 SHALL be a Moore FSM; outputs SHALL decode from the state register only, except ir_write/pc_write in FETCH and mem_write in MEM_WRITE, which SHALL be gated by mem_ready.
REQ-004 States (codes 0-14): FETCH, DECODE, MEM_ADR, MEM_READ, MEM_WB, MEM_WRITE, EXECUTE, ALU_WB, BRANCH, IMM_EXEC, IMM_WB, JUMP, JAL, IRQ, TRAP.
REQ-005 Opcodes: R=0, j=2, jal=3, beq=4, bne=5, addi=8, andi=12, ori=13, lw=35, sw=43; any other opcode is illegal.
REQ-006 FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=1, alu_op=00, pc_src=0; ir_write=pc_write=mem_ready; stays in FETCH while mem_ready=0; on mem_ready=1 goes to DECODE.
REQ-007 DECODE: alu_src_a=0, alu_src_b=3, alu_op=00; next = MEM_ADR (lw/sw), EXECUTE (R), BRANCH (beq/bne), IMM_EXEC (addi/andi/ori), JUMP (j), JAL (jal), TRAP with illegal_op=1 (other).
REQ-008 MEM_ADR: alu_src_a=1, alu_src_b=2, alu_op=00; next MEM_READ (lw) or MEM_WRITE (sw).
REQ-009 MEM_READ: mem_read=1, i_or_d=1, waits on mem_ready, then MEM_WB: reg_dst=0, mem_to_reg=1, reg_write=1.
REQ-010 MEM_WRITE: i_or_d=1, mem_write=mem_ready, waits on mem_ready, then end of instruction.
REQ-011 EXECUTE: alu_src_a=1, alu_src_b=0, alu_op=10; then ALU_WB: reg_dst=1, mem_to_reg=0, reg_write=1.
REQ-012 BRANCH: alu_src_a=1, alu_src_b=0, alu_op=01, pc_src=1, branch=1 (beq) or branch_ne=1 (bne); one cycle.
REQ-013 IMM_EXEC: alu_src_a=1, alu_src_b=2, alu_op=00 (addi) or 11 (andi/ori); then IMM_WB: reg_dst=0, mem_to_reg=0, reg_write=1.
REQ-014 JUMP: pc_src=2, pc_write=1. JAL: pc_src=2, pc_write=1, reg_dst=2, mem_to_reg=2, reg_write=1; one cycle each.
REQ-015 End of instruction (leaving MEM_WB, MEM_WRITE, ALU_WB, BRANCH, IMM_WB, JUMP, JAL) SHALL go to FETCH, or to IRQ per REQ-020.
REQ-016 A TMO_W-bit wait counter SHALL count consecutive mem_ready=0 cycles in FETCH/MEM_READ/MEM_WRITE, clear on mem_ready=1 or state change; reaching TMO_CYC SHALL enter TRAP with mem_timeout=1.
REQ-017 TRAP SHALL be absorbing until reset; all strobes 0; illegal_op/mem_timeout held.
REQ-018 Strobes not listed for a state SHALL be 0; unlisted mux selects SHALL be 0.

Reset
REQ-019 rst_n=0 SHALL asynchronously force state=FETCH, wait counter=0, status outputs=0, at any time including mid-wait or in TRAP; first fetch begins on the first rising edge after deassertion.

Configuration
REQ-020 Macro MC_CTRL_IRQ_EN defined: at end of instruction with irq=1, enter IRQ for one cycle: pc_src=IRQ_VEC_SEL, pc_write=1, irq_ack=1, then FETCH; irq is ignored mid-instruction. Undefined: irq ignored, irq_ack tied 0, IRQ state unreachable.

Structure
REQ-021 Package mc_ctrl_pkg SHALL hold opcode constants, state enum, alu_op/pc_src/reg_dst/mem_to_reg encodings.
REQ-022 Sub-module mc_ctrl_wait_timer SHALL implement the REQ-016 counter.

Verification
REQ-023 Reset, then lw (35) with mem_ready=1 -> states 0,1,2,3,4,0; reg_write=1 only in MEM_WB.
REQ-024 Fetch with mem_ready=0 for 3 cycles -> FETCH held 4 cycles, ir_write pulses once on the 4th cycle.
REQ-025 mem_ready held 0 in MEM_READ, TMO_CYC=15 -> TRAP after 15 wait cycles, mem_timeout=1 until rst_n=0.
REQ-026 Opcode 63 -> DECODE then TRAP, illegal_op=1; jal (3) -> JAL with reg_dst=2, mem_to_reg=2.
REQ-027 With MC_CTRL_IRQ_EN, irq=1 during R-type EXECUTE -> ALU_WB completes, IRQ (pc_src=3, irq_ack=1) one cycle, then FETCH; without the macro -> direct FETCH.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg -- shared definitions for the multi-cycle control FSM.
//   Opcode constants, the state enum (codes 0-14), the instruction class
//   enum, datapath mux encodings and the per-state control word decoder.
//   Optional feature macro used by the FSM: MC_CTRL_IRQ_EN.
package mc_ctrl_pkg;

  localparam int OPC_R    = 0;
  localparam int OPC_J    = 2;
  localparam int OPC_JAL  = 3;
  localparam int OPC_BEQ  = 4;
  localparam int OPC_BNE  = 5;
  localparam int OPC_ADDI = 8;
  localparam int OPC_ANDI = 12;
  localparam int OPC_ORI  = 13;
  localparam int OPC_LW   = 35;
  localparam int OPC_SW   = 43;

  typedef enum logic [3:0] {
    ST_FETCH     = 4'd0,
    ST_DECODE    = 4'd1,
    ST_MEM_ADR   = 4'd2,
    ST_MEM_READ  = 4'd3,
    ST_MEM_WB    = 4'd4,
    ST_MEM_WRITE = 4'd5,
    ST_EXECUTE   = 4'd6,
    ST_ALU_WB    = 4'd7,
    ST_BRANCH    = 4'd8,
    ST_IMM_EXEC  = 4'd9,
    ST_IMM_WB    = 4'd10,
    ST_JUMP      = 4'd11,
    ST_JAL       = 4'd12,
    ST_IRQ       = 4'd13,
    ST_TRAP      = 4'd14
  } state_e;

  typedef enum logic [3:0] {
    INS_R, INS_J, INS_JAL, INS_BEQ, INS_BNE, INS_ADDI,
    INS_ANDI, INS_ORI, INS_LW, INS_SW, INS_ILL
  } instr_e;

  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_SUB   = 2'd1;
  localparam logic [1:0] ALU_FUNCT = 2'd2;
  localparam logic [1:0] ALU_LOGIC = 2'd3;

  localparam logic [1:0] SRCB_REG    = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

  localparam logic [1:0] PC_ALU    = 2'd0;
  localparam logic [1:0] PC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;

  localparam logic [1:0] RDST_RT = 2'd0;
  localparam logic [1:0] RDST_RD = 2'd1;
  localparam logic [1:0] RDST_RA = 2'd2;

  localparam logic [1:0] M2R_ALU = 2'd0;
  localparam logic [1:0] M2R_MDR = 2'd1;
  localparam logic [1:0] M2R_PC  = 2'd2;

  // Control word held in the output register. rdy_gate marks states whose
  // write strobes (ir_write/pc_write/mem_write) only fire with mem_ready.
  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic [1:0] pc_src;
    logic       i_or_d;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       pc_write;
    logic       branch;
    logic       branch_ne;
    logic       reg_write;
    logic       irq_ack;
    logic       rdy_gate;
  } ctl_t;

  function automatic instr_e classify(input logic [31:0] op);
    instr_e r;
    r = INS_ILL;
    case (op)
      OPC_R:    r = INS_R;
      OPC_J:    r = INS_J;
      OPC_JAL:  r = INS_JAL;
      OPC_BEQ:  r = INS_BEQ;
      OPC_BNE:  r = INS_BNE;
      OPC_ADDI: r = INS_ADDI;
      OPC_ANDI: r = INS_ANDI;
      OPC_ORI:  r = INS_ORI;
      OPC_LW:   r = INS_LW;
      OPC_SW:   r = INS_SW;
      default:  r = INS_ILL;
    endcase
    return r;
  endfunction

  // Anything not set for a state stays 0 (strobes off, mux selects 0).
  function automatic ctl_t ctrl_decode(input state_e st, input instr_e ins,
                                       input logic [1:0] irq_vec);
    ctl_t c;
    c = '0;
    case (st)
      ST_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        c.ir_write  = 1'b1;
        c.pc_write  = 1'b1;
        c.rdy_gate  = 1'b1;
      end
      ST_DECODE:    c.alu_src_b = SRCB_IMM_SH;
      ST_MEM_ADR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
      end
      ST_MEM_READ: begin
        c.mem_read = 1'b1;
        c.i_or_d   = 1'b1;
      end
      ST_MEM_WB: begin
        c.reg_dst    = RDST_RT;
        c.mem_to_reg = M2R_MDR;
        c.reg_write  = 1'b1;
      end
      ST_MEM_WRITE: begin
        c.i_or_d    = 1'b1;
        c.mem_write = 1'b1;
        c.rdy_gate  = 1'b1;
      end
      ST_EXECUTE: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_REG;
        c.alu_op    = ALU_FUNCT;
      end
      ST_ALU_WB: begin
        c.reg_dst   = RDST_RD;
        c.reg_write = 1'b1;
      end
      ST_BRANCH: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = ALU_SUB;
        c.pc_src    = PC_ALUOUT;
        c.branch    = (ins == INS_BEQ);
        c.branch_ne = (ins == INS_BNE);
      end
      ST_IMM_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = (ins == INS_ADDI) ? ALU_ADD : ALU_LOGIC;
      end
      ST_IMM_WB:    c.reg_write = 1'b1;
      ST_JUMP: begin
        c.pc_src   = PC_JUMP;
        c.pc_write = 1'b1;
      end
      ST_JAL: begin
        c.pc_src     = PC_JUMP;
        c.pc_write   = 1'b1;
        c.reg_dst    = RDST_RA;
        c.mem_to_reg = M2R_PC;
        c.reg_write  = 1'b1;
      end
      ST_IRQ: begin
        c.pc_src   = irq_vec;
        c.pc_write = 1'b1;
        c.irq_ack  = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mc_ctrl_wait_timer.sv
// mc_ctrl_wait_timer -- counts consecutive memory-stall cycles.
//   clk, rst_n : clock, asynchronous active-low reset
//   wait_i     : FSM is in a state that waits on memory
//   ready_i    : memory completes the access this cycle
//   clr_i      : FSM state changes at the coming edge
//   expire_o   : this is stall cycle number TMO_CYC (leave for TRAP now)
module mc_ctrl_wait_timer #(
  parameter int TMO_CYC = 15,
  parameter int TMO_W   = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic wait_i,
  input  logic ready_i,
  input  logic clr_i,
  output logic expire_o
);

  logic [TMO_W-1:0] cnt_q, cnt_d;
  logic             stall;

  assign stall = wait_i & ~ready_i;
  // cnt_q holds the stalls already seen, so the TMO_CYC-th stall sees TMO_CYC-1.
  assign expire_o = stall && (cnt_q == TMO_W'(TMO_CYC - 1));

  always_comb begin
    cnt_d = '0;
    if (stall && !clr_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm -- Moore control FSM for a multi-cycle MIPS-like datapath.
//   Inputs : clk, rst_n (async, active low), opcode[OP_W], mem_ready, irq
//   Outputs: alu_op, alu_src_a, alu_src_b, reg_dst, mem_to_reg, pc_src,
//            i_or_d, ir_write, mem_read, mem_write, pc_write, branch,
//            branch_ne, reg_write, irq_ack, illegal_op, mem_timeout, state
//   Macro MC_CTRL_IRQ_EN enables the end-of-instruction interrupt entry.
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int OP_W        = 6,
  parameter int TMO_CYC     = 15,
  parameter int TMO_W       = 4,
  parameter int IRQ_VEC_SEL = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [OP_W-1:0] opcode,
  input  logic            mem_ready,
  input  logic            irq,
  output logic [1:0]      alu_op,
  output logic            alu_src_a,
  output logic [1:0]      alu_src_b,
  output logic [1:0]      reg_dst,
  output logic [1:0]      mem_to_reg,
  output logic            i_or_d,
  output logic            ir_write,
  output logic            mem_read,
  output logic            mem_write,
  output logic            pc_write,
  output logic            branch,
  output logic            branch_ne,
  output logic            reg_write,
  output logic [1:0]      pc_src,
  output logic            irq_ack,
  output logic            illegal_op,
  output logic            mem_timeout,
  output logic [3:0]      state
);

  localparam logic [1:0] IRQ_VEC = 2'(IRQ_VEC_SEL);

  state_e state_q, state_d, end_next;
  ctl_t   ctl_q;
  instr_e ins;
  logic   illegal_q, tmo_q;
  logic   tmo_expire, irq_take, in_wait;

  assign ins = classify(32'(opcode));

`ifdef MC_CTRL_IRQ_EN
  assign irq_take = irq;
  assign irq_ack  = ctl_q.irq_ack;
`else
  logic unused_irq;
  assign irq_take   = 1'b0;
  assign irq_ack    = 1'b0;
  assign unused_irq = irq ^ ctl_q.irq_ack;
`endif

  assign end_next = irq_take ? ST_IRQ : ST_FETCH;
  assign in_wait  = (state_q == ST_FETCH) || (state_q == ST_MEM_READ) ||
                    (state_q == ST_MEM_WRITE);

  mc_ctrl_wait_timer #(
    .TMO_CYC (TMO_CYC),
    .TMO_W   (TMO_W)
  ) u_wait_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .wait_i   (in_wait),
    .ready_i  (mem_ready),
    .clr_i    (state_d != state_q),
    .expire_o (tmo_expire)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH: begin
        if (tmo_expire)     state_d = ST_TRAP;
        else if (mem_ready) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        case (ins)
          INS_LW, INS_SW:             state_d = ST_MEM_ADR;
          INS_R:                      state_d = ST_EXECUTE;
          INS_BEQ, INS_BNE:           state_d = ST_BRANCH;
          INS_ADDI, INS_ANDI, INS_ORI: state_d = ST_IMM_EXEC;
          INS_J:                      state_d = ST_JUMP;
          INS_JAL:                    state_d = ST_JAL;
          default:                    state_d = ST_TRAP;
        endcase
      end
      ST_MEM_ADR:  state_d = (ins == INS_SW) ? ST_MEM_WRITE : ST_MEM_READ;
      ST_MEM_READ: begin
        if (tmo_expire)     state_d = ST_TRAP;
        else if (mem_ready) state_d = ST_MEM_WB;
      end
      ST_MEM_WRITE: begin
        if (tmo_expire)     state_d = ST_TRAP;
        else if (mem_ready) state_d = end_next;
      end
      ST_EXECUTE:  state_d = ST_ALU_WB;
      ST_IMM_EXEC: state_d = ST_IMM_WB;
      ST_MEM_WB, ST_ALU_WB, ST_BRANCH, ST_IMM_WB, ST_JUMP, ST_JAL:
                   state_d = end_next;
      ST_IRQ:      state_d = ST_FETCH;
      ST_TRAP:     state_d = ST_TRAP;
      default:     state_d = ST_FETCH;
    endcase
  end

  // The control word is registered from the next state, so it always
  // matches state_q; opcode is stable from DECODE until the next FETCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_FETCH;
      ctl_q     <= ctrl_decode(ST_FETCH, INS_ILL, IRQ_VEC);
      illegal_q <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      ctl_q   <= ctrl_decode(state_d, ins, IRQ_VEC);
      if (state_q == ST_DECODE && state_d == ST_TRAP) illegal_q <= 1'b1;
      if (tmo_expire)                                 tmo_q     <= 1'b1;
    end
  end

  assign alu_op      = ctl_q.alu_op;
  assign alu_src_a   = ctl_q.alu_src_a;
  assign alu_src_b   = ctl_q.alu_src_b;
  assign reg_dst     = ctl_q.reg_dst;
  assign mem_to_reg  = ctl_q.mem_to_reg;
  assign pc_src      = ctl_q.pc_src;
  assign i_or_d      = ctl_q.i_or_d;
  assign mem_read    = ctl_q.mem_read;
  assign branch      = ctl_q.branch;
  assign branch_ne   = ctl_q.branch_ne;
  assign reg_write   = ctl_q.reg_write;
  assign ir_write    = ctl_q.ir_write  & (~ctl_q.rdy_gate | mem_ready);
  assign pc_write    = ctl_q.pc_write  & (~ctl_q.rdy_gate | mem_ready);
  assign mem_write   = ctl_q.mem_write & (~ctl_q.rdy_gate | mem_ready);
  assign illegal_op  = illegal_q;
  assign mem_timeout = tmo_q;
  assign state       = state_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm -- randomized bench for mc_ctrl_fsm.
//   A planner turns each instruction (opcode, fetch/memory stall lengths,
//   irq pattern) into the cycle-by-cycle state walk the instruction set
//   implies; the driver plays it and queues the expected output word per
//   cycle, and a negedge monitor pops and compares. Define MC_CTRL_IRQ_EN
//   to exercise the interrupt build.
module tb_mc_ctrl_fsm;

  localparam int TMO = 15;
  localparam int VEC = 3;
`ifdef MC_CTRL_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  localparam int S_FETCH = 0, S_DECODE = 1, S_MEM_ADR = 2, S_MEM_READ = 3;
  localparam int S_MEM_WB = 4, S_MEM_WRITE = 5, S_EXECUTE = 6, S_ALU_WB = 7;
  localparam int S_BRANCH = 8, S_IMM_EXEC = 9, S_IMM_WB = 10, S_JUMP = 11;
  localparam int S_JAL = 12, S_IRQ = 13, S_TRAP = 14;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = '0;
  logic       mem_ready = 1'b0;
  logic       irq = 1'b0;
  logic [1:0] alu_op, alu_src_b, reg_dst, mem_to_reg, pc_src;
  logic       alu_src_a, i_or_d, ir_write, mem_read, mem_write, pc_write;
  logic       branch, branch_ne, reg_write, irq_ack, illegal_op, mem_timeout;
  logic [3:0] state;

  always #5 clk = ~clk;

  mc_ctrl_fsm #(
    .OP_W(6), .TMO_CYC(TMO), .TMO_W(4), .IRQ_VEC_SEL(VEC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .irq(irq), .alu_op(alu_op), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .i_or_d(i_or_d), .ir_write(ir_write), .mem_read(mem_read),
    .mem_write(mem_write), .pc_write(pc_write), .branch(branch),
    .branch_ne(branch_ne), .reg_write(reg_write), .pc_src(pc_src),
    .irq_ack(irq_ack), .illegal_op(illegal_op), .mem_timeout(mem_timeout),
    .state(state)
  );

  typedef struct {
    int st;
    bit rdy;
    bit irq;
    bit ill;
    bit tmo;
  } step_t;

  step_t       steps[$];
  logic [25:0] sb_q[$];
  int          errors = 0;
  int          checks = 0;
  bit          mon_on = 1'b0;
  int          txn = 0;
  int          legal_ops[10] = '{0, 2, 3, 4, 5, 8, 12, 13, 35, 43};

  // Expected output word from the per-state behaviour of the controller.
  function automatic logic [25:0] exp_vec(input int st, input bit rdy,
                                          input int op, input bit ill,
                                          input bit tmo);
    logic [1:0] aop, srcb, rdst, m2r, psrc;
    logic srca, iord, irw, mrd, mwr, pcw, br, bne, rw, ack;
    {aop, srcb, rdst, m2r, psrc} = '0;
    {srca, iord, irw, mrd, mwr, pcw, br, bne, rw, ack} = '0;
    case (st)
      S_FETCH:     begin mrd = 1; srcb = 1; irw = rdy; pcw = rdy; end
      S_DECODE:    srcb = 3;
      S_MEM_ADR:   begin srca = 1; srcb = 2; end
      S_MEM_READ:  begin mrd = 1; iord = 1; end
      S_MEM_WB:    begin m2r = 1; rw = 1; end
      S_MEM_WRITE: begin iord = 1; mwr = rdy; end
      S_EXECUTE:   begin srca = 1; aop = 2; end
      S_ALU_WB:    begin rdst = 1; rw = 1; end
      S_BRANCH:    begin srca = 1; aop = 1; psrc = 1; br = (op == 4); bne = (op == 5); end
      S_IMM_EXEC:  begin srca = 1; srcb = 2; aop = (op == 8) ? 2'd0 : 2'd3; end
      S_IMM_WB:    rw = 1;
      S_JUMP:      begin psrc = 2; pcw = 1; end
      S_JAL:       begin psrc = 2; pcw = 1; rdst = 2; m2r = 2; rw = 1; end
      S_IRQ:       begin psrc = 2'(VEC); pcw = 1; ack = 1; end
      default: ;
    endcase
    return {4'(st), aop, srca, srcb, rdst, m2r, iord, irw, mrd, mwr, pcw,
            br, bne, rw, psrc, ack, (st == S_TRAP) && ill, (st == S_TRAP) && tmo};
  endfunction

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic bit is_legal(input int op);
    foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  // irq mode: 0 random per cycle, 1 always high, 2 always low
  task automatic add(input int st, input bit rdy, input int im, input bit ill, input bit tmo);
    step_t s;
    s.st  = st;
    s.rdy = rdy;
    s.irq = (im == 1) ? 1'b1 : (im == 2) ? 1'b0 : rb();
    s.ill = ill;
    s.tmo = tmo;
    steps.push_back(s);
  endtask

  task automatic add_trap(input bit ill, input bit tmo, input int im);
    for (int i = 0; i < 3; i++) add(S_TRAP, rb(), im, ill, tmo);
  endtask

  task automatic plan(input int op, input int fw, input int mw, input int im);
    int tgt;
    steps.delete();
    for (int i = 0; i < fw && i < TMO; i++) add(S_FETCH, 1'b0, im, 0, 0);
    if (fw >= TMO) begin add_trap(0, 1, im); return; end
    add(S_FETCH, 1'b1, im, 0, 0);
    add(S_DECODE, rb(), im, 0, 0);
    case (op)
      35, 43: begin
        add(S_MEM_ADR, rb(), im, 0, 0);
        tgt = (op == 35) ? S_MEM_READ : S_MEM_WRITE;
        for (int i = 0; i < mw && i < TMO; i++) add(tgt, 1'b0, im, 0, 0);
        if (mw >= TMO) begin add_trap(0, 1, im); return; end
        add(tgt, 1'b1, im, 0, 0);
        if (op == 35) add(S_MEM_WB, rb(), im, 0, 0);
      end
      0:        begin add(S_EXECUTE, rb(), im, 0, 0); add(S_ALU_WB, rb(), im, 0, 0); end
      4, 5:     add(S_BRANCH, rb(), im, 0, 0);
      8, 12, 13: begin add(S_IMM_EXEC, rb(), im, 0, 0); add(S_IMM_WB, rb(), im, 0, 0); end
      2:        add(S_JUMP, rb(), im, 0, 0);
      3:        add(S_JAL, rb(), im, 0, 0);
      default:  begin add_trap(1, 0, im); return; end
    endcase
    // irq is only looked at in the last cycle of the instruction
    if (IRQ_EN && steps[steps.size()-1].irq) add(S_IRQ, rb(), im, 0, 0);
  endtask

  task automatic push_exp(input int st, input bit rdy, input int op, input bit ill, input bit tmo);
    sb_q.push_back(exp_vec(st, rdy, op, ill, tmo));
    mon_on = 1'b1;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      mem_ready = 1'b0;
      irq = rb();
      push_exp(S_FETCH, 1'b0, 0, 0, 0);
    end
  endtask

  // trunc > 0: stop after that many cycles and reset mid-instruction
  task automatic run(input int op, input int fw, input int mw, input int im, input int trunc);
    int n;
    plan(op, fw, mw, im);
    n = (trunc > 0 && trunc < steps.size()) ? trunc : steps.size();
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      opcode = 6'(op);
      mem_ready = steps[i].rdy;
      irq = steps[i].irq;
      push_exp(steps[i].st, steps[i].rdy, op, steps[i].ill, steps[i].tmo);
    end
    $display("txn %0d op=%0d fw=%0d mw=%0d irq_mode=%0d cycles=%0d last_state=%0d",
             txn, op, fw, mw, im, n, steps[n-1].st);
    txn++;
    if (trunc > 0 || steps[n-1].st == S_TRAP) do_reset(2);
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      logic [25:0] act, want;
      checks++;
      act = {state, alu_op, alu_src_a, alu_src_b, reg_dst, mem_to_reg, i_or_d,
             ir_write, mem_read, mem_write, pc_write, branch, branch_ne,
             reg_write, pc_src, irq_ack, illegal_op, mem_timeout};
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_underflow t=%0t got=%h want=<none>", $time, act);
      end else begin
        want = sb_q.pop_front();
        if (act !== want) begin
          errors++;
          $display("FAIL cycle_outputs t=%0t state got=%0d want=%0d word got=%h want=%h",
                   $time, act[25:22], want[25:22], act, want);
        end
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int op, fw, mw, r;
    do_reset(2);
    run(35, 0, 0, 2, 0);    // lw: 0,1,2,3,4,0
    run(0, 3, 0, 2, 0);     // fetch stalled 3 cycles
    run(35, 0, 15, 2, 0);   // MEM_READ timeout -> TRAP, then reset
    run(63, 0, 0, 2, 0);    // illegal opcode -> TRAP
    run(3, 0, 0, 2, 0);     // jal
    run(0, 0, 0, 1, 0);     // R-type with irq held high
    run(43, 1, 14, 2, 0);   // sw, one short of timeout
    run(43, 0, 15, 2, 0);   // sw timeout
    run(0, 10, 0, 2, 6);    // reset while stalled in FETCH
    run(4, 14, 0, 2, 0);    // counter must have been cleared by reset
    run(5, 15, 0, 2, 0);    // fetch timeout
    run(13, 0, 0, 1, 0);
    run(8, 0, 0, 1, 0);
    run(12, 2, 0, 0, 0);
    run(2, 0, 0, 1, 0);
    for (int k = 0; k < 80; k++) begin
      r = $urandom_range(0, 10);
      if (r == 10) begin
        do op = $urandom_range(0, 63); while (is_legal(op));
      end else op = legal_ops[r];
      r  = $urandom_range(0, 29);
      fw = (r == 0) ? TMO : (r == 1) ? TMO - 1 : $urandom_range(0, 3);
      r  = $urandom_range(0, 29);
      mw = (r == 0) ? TMO : (r == 1) ? TMO - 1 : $urandom_range(0, 3);
      run(op, fw, mw, 0, 0);
    end
    @(negedge clk);
    #1;
    mon_on = 1'b0;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain leftover got=%0d want=0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
